// File: rtl/busy_table_fp.sv
// FP physical-register busy scoreboard feeding the FP issue queue source-ready lookups.
// Optional same-cycle writeback wakeup bypass is compiled in with FP_BUSY_BYPASS_EN.
`ifndef IQ_FP_SIZE
`define IQ_FP_SIZE 32
`endif
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 4
`endif

module busy_table_fp #(
  parameter int PRF_SIZE       = 64,
  parameter int PRF_INDEX_SIZE = $clog2(PRF_SIZE),
  parameter int IQ_SIZE        = `IQ_FP_SIZE,
  parameter int DISPATCH_WIDTH = `DISPATCH_WIDTH,
  parameter int WB_WIDTH       = 2
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic                                           flush,
  input  logic [DISPATCH_WIDTH-1:0]                      alloc_valid,
  input  logic [DISPATCH_WIDTH-1:0][PRF_INDEX_SIZE-1:0]  alloc_index,
  input  logic [WB_WIDTH-1:0]                            wb_valid,
  input  logic [WB_WIDTH-1:0][PRF_INDEX_SIZE-1:0]        wb_index,
  input  logic [IQ_SIZE-1:0][PRF_INDEX_SIZE-1:0]         rs1_index,
  input  logic [IQ_SIZE-1:0][PRF_INDEX_SIZE-1:0]         rs2_index,
  input  logic [IQ_SIZE-1:0][PRF_INDEX_SIZE-1:0]         rs3_index,
  output logic [IQ_SIZE-1:0]                             rs1_busy,
  output logic [IQ_SIZE-1:0]                             rs2_busy,
  output logic [IQ_SIZE-1:0]                             rs3_busy,
  output logic [$clog2(PRF_SIZE):0]                      busy_count
);

  localparam int CNT_W = $clog2(PRF_SIZE) + 1;

  logic [PRF_SIZE-1:0] busy_q;
  logic [PRF_SIZE-1:0] busy_d;
  logic [PRF_SIZE-1:0] set_s;
  logic [PRF_SIZE-1:0] clr_s;
  logic [PRF_SIZE-1:0] wake_s;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;

  // Busy bit of one source index, masked by entries woken this cycle; out-of-range reads 0.
  function automatic logic lookup(input logic [PRF_SIZE-1:0]       state,
                                  input logic [PRF_SIZE-1:0]       wake,
                                  input logic [PRF_INDEX_SIZE-1:0] idx);
    logic hit;
    hit = 1'b0;
    for (int e = 0; e < PRF_SIZE; e++) begin
      hit = hit | (state[e] & ~wake[e] & (idx == PRF_INDEX_SIZE'(e)));
    end
    return hit;
  endfunction

  // Decode alloc lanes and writeback ports into per-entry set/clear masks.
  always_comb begin
    set_s = '0;
    clr_s = '0;
    for (int e = 0; e < PRF_SIZE; e++) begin
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        set_s[e] = set_s[e] | (alloc_valid[i] & (alloc_index[i] == PRF_INDEX_SIZE'(e)));
      end
      for (int j = 0; j < WB_WIDTH; j++) begin
        clr_s[e] = clr_s[e] | (wb_valid[j] & (wb_index[j] == PRF_INDEX_SIZE'(e)));
      end
    end
  end

  // Next state: reset/flush dominate, then set wins over clear; entry 0 never busy.
  always_comb begin
    busy_d = busy_q;
    if (reset || flush) begin
      busy_d = '0;
    end else begin
      busy_d = (busy_q & ~clr_s) | set_s;
    end
    busy_d[0] = 1'b0;
    count_d = '0;
    for (int e = 0; e < PRF_SIZE; e++) begin
      count_d = count_d + CNT_W'(busy_d[e]);
    end
  end

  // State and population-count registers.
  always_ff @(posedge clock) begin
    busy_q  <= busy_d;
    count_q <= count_d;
  end

  // Writebacks not re-allocated this cycle may wake consumers immediately when bypass is built in.
  always_comb begin
`ifdef FP_BUSY_BYPASS_EN
    wake_s = clr_s & ~set_s;
`else
    wake_s = '0;
`endif
  end

  // Per-slot source lookups from registered state.
  always_comb begin
    rs1_busy = '0;
    rs2_busy = '0;
    rs3_busy = '0;
    for (int k = 0; k < IQ_SIZE; k++) begin
      rs1_busy[k] = lookup(busy_q, wake_s, rs1_index[k]);
      rs2_busy[k] = lookup(busy_q, wake_s, rs2_index[k]);
      rs3_busy[k] = lookup(busy_q, wake_s, rs3_index[k]);
    end
  end

  assign busy_count = count_q;

endmodule
